pkt_gen_task_arbiter: RTL and testbench

//  Round-robin task arbiter between the per-flow token-bucket engine and the task FIFO.

---
 rtl/pkt_gen_task_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_pkt_gen_task_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_gen_task_arbiter.sv
// pkt_gen_task_arbiter
//   Round-robin arbiter between the per-flow token-bucket engine and the task
//   FIFO. Each "flow N earned a packet of size S" request raises a saturating
//   pending count for that flow. Enabled flows with work are granted fairly,
//   one task per grant, on a valid/ready output, so one hot flow cannot starve
//   the others.
//
//   clk_i, rst_i        clock, synchronous active-high reset
//   flow_en_i           per-flow enable (level). A low enable flushes that flow.
//   req_*_i             request strobe, flow number and packet size (no ready)
//   req_drop_o          one-cycle pulse: last cycle's request was discarded
//   task_*_o            granted flow and packet size, valid/ready handshake
//   task_ready_i        downstream FIFO accepts the task
//   pending_any_o       registered "some enabled flow has work" (one-cycle lag)

// Per-flow state: a saturating pending counter and the last accepted size.
module pkt_gen_task_arbiter_flow #(
  parameter int PEND_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        req_hit_i,
  input  logic [15:0] req_size_i,
  input  logic        grant_i,
  output logic        elig_o,
  output logic        accept_o,
  output logic [15:0] size_o
);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic [15:0]           size_q, size_d;

  // Full or disabled flows refuse the request; the top turns that into a drop.
  assign accept_o = en_i && req_hit_i && (pend_q != PEND_MAX);
  assign elig_o   = en_i && (pend_q != '0);
  assign size_o   = size_q;

  always_comb begin
    pend_d = pend_q;
    size_d = size_q;
    if (!en_i) begin
      // Disable flushes the backlog and beats any same-cycle request.
      pend_d = '0;
    end else begin
      if (accept_o) size_d = req_size_i;
      // A grant is only issued while eligible, so pend_q != 0 on decrement.
      // Accept and grant together leave the count unchanged.
      unique case ({accept_o, grant_i})
        2'b10:   pend_d = pend_q + PEND_ONE;
        2'b01:   pend_d = pend_q - PEND_ONE;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      size_q <= '0;
    end else begin
      pend_q <= pend_d;
      size_q <= size_d;
    end
  end
endmodule

module pkt_gen_task_arbiter #(
  parameter  int FLOW_CNT       = 16,
  parameter  int PEND_WIDTH     = 4,
  localparam int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT-1:0]       flow_en_i,
  input  logic [FLOW_CNT_WIDTH-1:0] req_flow_num_i,
  input  logic [15:0]               req_pkt_size_i,
  input  logic                      req_valid_i,
  output logic                      req_drop_o,
  output logic [FLOW_CNT_WIDTH-1:0] task_flow_num_o,
  output logic [15:0]               task_pkt_size_o,
  output logic                      task_valid_o,
  input  logic                      task_ready_i,
  output logic                      pending_any_o
);
  localparam logic [FLOW_CNT_WIDTH-1:0] LAST_FLOW = FLOW_CNT_WIDTH'(FLOW_CNT - 1);

  logic [FLOW_CNT-1:0]        req_hit, grant_hit, elig, accept;
  logic [FLOW_CNT-1:0][15:0]  flow_size;

  logic                       grant_found, load, grant;
  logic [FLOW_CNT_WIDTH-1:0]  grant_idx;

  logic [FLOW_CNT_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic                       task_valid_q, task_valid_d;
  logic [FLOW_CNT_WIDTH-1:0]  task_flow_q, task_flow_d;
  logic [15:0]                task_size_q, task_size_d;
  logic                       req_drop_q, req_drop_d;
  logic                       pending_any_q, pending_any_d;

  // Output register is free, or is being drained this cycle.
  assign load  = !task_valid_q || task_ready_i;
  assign grant = load && grant_found;

  for (genvar f = 0; f < FLOW_CNT; f++) begin : g_flow
    assign req_hit[f]   = req_valid_i && (req_flow_num_i == FLOW_CNT_WIDTH'(f));
    assign grant_hit[f] = grant && (grant_idx == FLOW_CNT_WIDTH'(f));

    pkt_gen_task_arbiter_flow #(.PEND_WIDTH(PEND_WIDTH)) u_flow (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (flow_en_i[f]),
      .req_hit_i  (req_hit[f]),
      .req_size_i (req_pkt_size_i),
      .grant_i    (grant_hit[f]),
      .elig_o     (elig[f]),
      .accept_o   (accept[f]),
      .size_o     (flow_size[f])
    );
  end

  // Round-robin search: first eligible flow after last_grant, wrapping.
  // k runs 1..FLOW_CNT so last_grant itself is considered last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= FLOW_CNT; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= FLOW_CNT) idx = idx - FLOW_CNT;
      if (!grant_found && elig[FLOW_CNT_WIDTH'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = FLOW_CNT_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    task_valid_d  = task_valid_q;
    task_flow_d   = task_flow_q;
    task_size_d   = task_size_q;
    if (load) begin
      task_valid_d = grant_found;
      if (grant_found) begin
        // Size read before the same-cycle request updates it.
        task_flow_d  = grant_idx;
        task_size_d  = flow_size[grant_idx];
        last_grant_d = grant_idx;
      end
    end
    // Out-of-range flow numbers match no flow and are dropped too.
    req_drop_d    = req_valid_i && !(|accept);
    pending_any_d = |elig;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q  <= LAST_FLOW;
      task_valid_q  <= 1'b0;
      task_flow_q   <= '0;
      task_size_q   <= '0;
      req_drop_q    <= 1'b0;
      pending_any_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      task_valid_q  <= task_valid_d;
      task_flow_q   <= task_flow_d;
      task_size_q   <= task_size_d;
      req_drop_q    <= req_drop_d;
      pending_any_q <= pending_any_d;
    end
  end

  assign task_valid_o    = task_valid_q;
  assign task_flow_num_o = task_flow_q;
  assign task_pkt_size_o = task_size_q;
  assign req_drop_o      = req_drop_q;
  assign pending_any_o   = pending_any_q;
endmodule

// File: tb/tb_pkt_gen_task_arbiter.sv
module tb_pkt_gen_task_arbiter;
  localparam int NF   = 4;
  localparam int PW   = 2;
  localparam int PMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flow_en;
  logic [1:0]  req_flow_num;
  logic [15:0] req_pkt_size;
  logic        req_valid;
  logic        req_drop;
  logic [1:0]  task_flow_num;
  logic [15:0] task_pkt_size;
  logic        task_valid;
  logic        task_ready;
  logic        pending_any;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference state: backlog count and latest size per flow, output register.
  int m_pend[NF];
  int m_size[NF];
  int m_last, m_tv, m_tf, m_ts, m_drop, m_pany;

  always #5 clk = ~clk;

  pkt_gen_task_arbiter #(.FLOW_CNT(NF), .PEND_WIDTH(PW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flow_en_i       (flow_en),
    .req_flow_num_i  (req_flow_num),
    .req_pkt_size_i  (req_pkt_size),
    .req_valid_i     (req_valid),
    .req_drop_o      (req_drop),
    .task_flow_num_o (task_flow_num),
    .task_pkt_size_o (task_pkt_size),
    .task_valid_o    (task_valid),
    .task_ready_i    (task_ready),
    .pending_any_o   (pending_any)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // One clock edge of the arbiter's rules, using the inputs held this cycle.
  task automatic model_step();
    int g, acc, f;
    bit load, any_e;
    bit e[NF];
    if (rst) begin
      for (int i = 0; i < NF; i++) begin m_pend[i] = 0; m_size[i] = 0; end
      m_last = NF - 1; m_tv = 0; m_tf = 0; m_ts = 0; m_drop = 0; m_pany = 0;
      return;
    end
    any_e = 0;
    for (int i = 0; i < NF; i++) begin
      e[i]  = flow_en[i] && (m_pend[i] != 0);
      any_e = any_e | e[i];
    end
    load = (m_tv == 0) || task_ready;
    g = -1;
    if (load)
      for (int k = 1; k <= NF; k++) begin
        f = (m_last + k) % NF;
        if (g < 0 && e[f]) g = f;
      end
    acc = -1;
    if (req_valid && flow_en[req_flow_num] && m_pend[int'(req_flow_num)] < PMAX)
      acc = int'(req_flow_num);
    m_drop = (req_valid && acc < 0) ? 1 : 0;
    m_pany = any_e ? 1 : 0;
    if (load) begin
      m_tv = (g >= 0) ? 1 : 0;
      if (g >= 0) begin m_tf = g; m_ts = m_size[g]; m_last = g; end
    end
    for (int i = 0; i < NF; i++) begin
      if (!flow_en[i]) m_pend[i] = 0;
      else begin
        if (acc == i) m_pend[i] = m_pend[i] + 1;
        if (g == i)   m_pend[i] = m_pend[i] - 1;
      end
    end
    if (acc >= 0) m_size[acc] = int'(req_pkt_size);
  endtask

  task automatic cmp_model();
    chk("mdl_valid", int'(task_valid), m_tv);
    if (m_tv != 0) begin
      chk("mdl_flow", int'(task_flow_num), m_tf);
      chk("mdl_size", int'(task_pkt_size), m_ts);
    end
    chk("mdl_drop", int'(req_drop), m_drop);
    chk("mdl_pany", int'(pending_any), m_pany);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic drv(input bit r, input logic [3:0] en, input bit rv,
                     input int rf, input int rs, input bit rdy);
    rst          = r;
    flow_en      = en;
    req_valid    = rv;
    req_flow_num = 2'(rf);
    req_pkt_size = 16'(rs);
    task_ready   = rdy;
  endtask

  typedef struct {
    bit rst; logic [3:0] en; bit rv; int rf; int rs; bit rdy;
    bit tv; int tf; int ts; bit drop; bit pany;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int exp_ord[6];
    int held_f, held_s, cnt3;

    drv(1, 4'b0000, 0, 0, 0, 0);

    // rst en rv rf rs rdy | tv tf ts drop pany
    tbl.push_back(vec_t'{1, 4'b0000, 0, 0,  0, 0, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 64, 1, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 1, 2, 64, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 1, 99, 1, 0, 0,  0, 1, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 10, 0, 0, 0,  0, 0, 0});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 11, 0, 1, 2, 10, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 12, 0, 1, 2, 10, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 13, 0, 1, 2, 10, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 1, 2, 14, 0, 1, 2, 10, 1, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 1, 2, 13, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 1, 2, 13, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 1, 2, 13, 0, 1});
    tbl.push_back(vec_t'{0, 4'b0100, 0, 0,  0, 1, 0, 0,  0, 0, 0});

    foreach (tbl[i]) begin
      drv(tbl[i].rst, tbl[i].en, tbl[i].rv, tbl[i].rf, tbl[i].rs, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_valid", i), int'(task_valid), int'(tbl[i].tv));
      if (tbl[i].tv) begin
        chk($sformatf("tbl%0d_flow", i), int'(task_flow_num), tbl[i].tf);
        chk($sformatf("tbl%0d_size", i), int'(task_pkt_size), tbl[i].ts);
      end
      chk($sformatf("tbl%0d_drop", i), int'(req_drop), int'(tbl[i].drop));
      chk($sformatf("tbl%0d_pany", i), int'(pending_any), int'(tbl[i].pany));
    end

    // Fair order with flow 2 disabled; flow 3 held first, then 2 each for 0,1,3.
    drv(1, 4'b0000, 0, 0, 0, 0); cycle();
    drv(0, 4'b1011, 1, 3, 30, 0); cycle();
    drv(0, 4'b1011, 1, 0, 1, 0);  cycle();
    drv(0, 4'b1011, 1, 0, 2, 0);  cycle();
    drv(0, 4'b1011, 1, 1, 3, 0);  cycle();
    drv(0, 4'b1011, 1, 1, 4, 0);  cycle();
    drv(0, 4'b1011, 1, 3, 5, 0);  cycle();
    drv(0, 4'b1011, 1, 3, 6, 0);  cycle();
    chk("rr_held_flow", int'(task_flow_num), 3);
    exp_ord = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 6; i++) begin
      drv(0, 4'b1011, 0, 0, 0, 1); cycle();
      chk($sformatf("rr_order%0d", i), int'(task_flow_num), exp_ord[i]);
    end
    drv(0, 4'b1011, 0, 0, 0, 1); cycle();
    chk("rr_drained", int'(task_valid), 0);

    // Backpressure: held task stays put while requests keep arriving.
    drv(0, 4'b1111, 1, 2, 77, 0); cycle();
    drv(0, 4'b1111, 1, 1, 5, 0);  cycle();
    held_f = int'(task_flow_num);
    held_s = int'(task_pkt_size);
    chk("hold_flow0", held_f, 2);
    chk("hold_size0", held_s, 77);
    for (int i = 0; i < 5; i++) begin
      drv(0, 4'b1111, 1, (i == 3) ? 2 : (i % 2) * 3, 88 + i, 0); cycle();
      chk($sformatf("hold_valid%0d", i), int'(task_valid), 1);
      chk($sformatf("hold_flow%0d", i + 1), int'(task_flow_num), held_f);
      chk($sformatf("hold_size%0d", i + 1), int'(task_pkt_size), held_s);
    end
    drv(0, 4'b1111, 0, 0, 0, 1); cycle();
    chk("hold_next_flow", int'(task_flow_num), 3);
    for (int i = 0; i < 10; i++) begin drv(0, 4'b1111, 0, 0, 0, 1); cycle(); end
    chk("hold_drained", int'(task_valid), 0);

    // Flush beats a same-cycle request; re-enabling brings nothing back.
    drv(0, 4'b1111, 1, 0, 9, 0);  cycle();
    drv(0, 4'b1111, 1, 3, 40, 0); cycle();
    drv(0, 4'b1111, 1, 3, 41, 0); cycle();
    drv(0, 4'b1111, 1, 3, 42, 0); cycle();
    drv(0, 4'b0111, 1, 3, 43, 0); cycle();
    chk("flush_drop", int'(req_drop), 1);
    cnt3 = 0;
    for (int i = 0; i < 6; i++) begin
      drv(0, 4'b1111, 0, 0, 0, 1); cycle();
      if (task_valid && task_flow_num == 2'd3) cnt3++;
    end
    chk("flush_no_flow3", cnt3, 0);
    chk("flush_idle", int'(task_valid), 0);

    // Reset while a task is held and flows have backlog.
    drv(0, 4'b1111, 1, 1, 21, 0); cycle();
    drv(0, 4'b1111, 1, 2, 22, 0); cycle();
    drv(0, 4'b1111, 1, 2, 23, 0); cycle();
    chk("rst_pre_valid", int'(task_valid), 1);
    drv(1, 4'b1111, 1, 2, 24, 0); cycle();
    chk("rst_valid", int'(task_valid), 0);
    chk("rst_flow", int'(task_flow_num), 0);
    chk("rst_size", int'(task_pkt_size), 0);
    chk("rst_drop", int'(req_drop), 0);
    chk("rst_pany", int'(pending_any), 0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 4'b1111, 0, 0, 0, 1); cycle();
      chk($sformatf("rst_quiet%0d", i), int'(task_valid), 0);
    end

    // Random traffic against the reference model.
    flow_en = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] en;
      en = flow_en;
      if ($urandom_range(0, 19) == 0) en = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      drv($urandom_range(0, 299) == 0, en, $urandom_range(0, 9) < 7,
          $urandom_range(0, NF - 1), $urandom_range(0, 65535), $urandom_range(0, 9) < 6);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
